// File: rtl/branch_gshare_pred.sv
// ---------------------------------------------------------------------------
// branch_gshare_pred
//   Gshare branch direction predictor with a parametrised saturating-counter
//   pattern history table (PHT). The PC index bits are XORed with the global
//   history register. HIST_BITS=0 reduces it to a bimodal predictor.
//   After reset the table is swept to weakly-not-taken, one entry per cycle,
//   before predictions are marked ready.
//
// Ports
//   clk          clock
//   reset        asynchronous active-low reset
//   pred_pc      fetch PC to predict (combinational lookup)
//   pred_ready   table initialised, prediction meaningful
//   prediction   1 = predict taken
//   update_en    resolved-branch training strobe
//   update_pc    PC of the resolved branch
//   update_taken actual branch outcome
//   ghr          current global history (0 when HIST_BITS=0)
//
// Build option
//   BRANCH_GSHARE_BYPASS_EN : when an update and a prediction hit the same
//   entry in the same cycle, the prediction uses the freshly computed counter.
// ---------------------------------------------------------------------------
module branch_gshare_pred #(
  parameter int unsigned PHT_SIZE  = 2048,
  parameter int unsigned CTR_BITS  = 2,
  parameter int unsigned HIST_BITS = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [31:0]                              pred_pc,
  output logic                                     pred_ready,
  output logic                                     prediction,
  input  logic                                     update_en,
  input  logic [31:0]                              update_pc,
  input  logic                                     update_taken,
  output logic [((HIST_BITS == 0) ? 1 : HIST_BITS)-1:0] ghr
);

  localparam int unsigned IDX = $clog2(PHT_SIZE);
  localparam int unsigned HW  = (HIST_BITS == 0) ? 1 : HIST_BITS;

  localparam logic [CTR_BITS-1:0] CTR_WNT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ONE = CTR_BITS'(1);
  localparam logic [IDX-1:0]      PTR_LAST = IDX'(PHT_SIZE - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  logic [IDX-1:0]      init_ptr;
  logic [HW-1:0]       ghr_q;
  logic [HW-1:0]       ghr_nxt;
  logic [IDX-1:0]      hist_fold;
  logic [IDX-1:0]      pred_idx;
  logic [IDX-1:0]      upd_idx;
  logic [CTR_BITS-1:0] ctr_upd_old;
  logic [CTR_BITS-1:0] ctr_upd_new;
  logic [CTR_BITS-1:0] ctr_pred;
  logic [CTR_BITS-1:0] pht [PHT_SIZE];

  // History folded to index width: zero-extend short histories, truncate long ones.
  generate
    if (HIST_BITS == 0) begin : g_fold_none
      assign hist_fold = '0;
    end else if (HIST_BITS <= IDX) begin : g_fold_ext
      assign hist_fold = IDX'(ghr_q);
    end else begin : g_fold_trunc
      assign hist_fold = ghr_q[IDX-1:0];
    end
  endgenerate

  // Next history value on a resolved branch.
  generate
    if (HIST_BITS == 0) begin : g_ghr_none
      assign ghr_nxt = '0;
    end else if (HIST_BITS == 1) begin : g_ghr_one
      assign ghr_nxt = update_taken;
    end else begin : g_ghr_shift
      assign ghr_nxt = {ghr_q[HW-2:0], update_taken};
    end
  endgenerate

  assign pred_idx = pred_pc[IDX+1:2] ^ hist_fold;
  assign upd_idx  = update_pc[IDX+1:2] ^ hist_fold;
  assign ghr      = ghr_q;

  // PC bits outside the index field do not affect the predictor.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX+2], pred_pc[1:0],
                            update_pc[31:IDX+2], update_pc[1:0]};

  // Saturating counter step for the training entry.
  always_comb begin
    ctr_upd_old = pht[upd_idx];
    ctr_upd_new = ctr_upd_old;
    if (update_taken) begin
      if (ctr_upd_old != CTR_MAX) ctr_upd_new = ctr_upd_old + CTR_ONE;
    end else begin
      if (ctr_upd_old != '0) ctr_upd_new = ctr_upd_old - CTR_ONE;
    end
  end

  // Prediction lookup, forced low until the sweep has finished.
  always_comb begin
    ctr_pred = pht[pred_idx];
`ifdef BRANCH_GSHARE_BYPASS_EN
    if (update_en && (upd_idx == pred_idx)) ctr_pred = ctr_upd_new;
`endif
    prediction = (state == ST_RUN) && ctr_pred[CTR_BITS-1];
  end

  // Control: init sweep pointer, run state, history register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      init_ptr   <= '0;
      ghr_q      <= '0;
      pred_ready <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + IDX'(1);
          if (init_ptr == PTR_LAST) begin
            state      <= ST_RUN;
            pred_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (update_en) ghr_q <= ghr_nxt;
        end
        default: begin
          state      <= ST_INIT;
          pred_ready <= 1'b0;
        end
      endcase
    end
  end

  // Counter table: sweep writes during init, training writes during run.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      pht[init_ptr] <= CTR_WNT;
    end else if (update_en) begin
      pht[upd_idx] <= ctr_upd_new;
    end
  end

endmodule

// File: doc/branch_gshare_pred.md
Name: branch_gshare_pred

Overview:
- Parametrised successor to the team's fixed 2-bit bimodal predictor.
- Adds configurable counter width and a global history register (GHR) XOR-folded into the index (gshare).
- Adds a reset-time table initialisation sweep and a prediction-valid handshake.
- Sits in the fetch stage: combinational lookup on pred_pc; trained from execute via the update port.
- HIST_BITS=0 degenerates to a bimodal predictor.

Parameters:
- PHT_SIZE, 2048, number of counter entries; power of two, >=2.
- CTR_BITS, 2, saturating counter width; 1..4.
- HIST_BITS, 8, GHR length in bits; 0..32.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- pred_pc  in  32  PC being fetched.
- pred_ready  out  1  table initialised; prediction is meaningful.
- prediction  out  1  1 = predict taken.
- update_en  in  1  resolved-branch update strobe.
- update_pc  in  32  PC of the resolved branch.
- update_taken  in  1  actual branch outcome.
- ghr  out  max(HIST_BITS,1)  current global history (0 when HIST_BITS=0).

Behaviour:
- IDX = log2(PHT_SIZE).
- Index function: idx(pc) = pc[IDX+1:2] XOR H.
  - H = ghr zero-extended to IDX bits if HIST_BITS <= IDX; otherwise the low IDX bits of ghr.
  - HIST_BITS=0: H = 0.
- Reset (reset=0, asynchronous):
  - state=INIT, init_ptr=0, ghr=0, pred_ready=0, prediction=0.
  - Reset asserted mid-INIT or mid-RUN restarts the sweep from entry 0.
- INIT state:
  - Each cycle writes WNT = 2^(CTR_BITS-1)-1 to entry init_ptr, then increments init_ptr.
  - After the write to entry PHT_SIZE-1, next state is RUN. Total INIT = PHT_SIZE cycles after reset deassertion.
  - update_en is ignored: no table write, no ghr shift. prediction forced 0; pred_ready=0.
- RUN state:
  - pred_ready=1.
  - prediction = MSB of counter[idx(pred_pc)], combinational from the current table and ghr.
  - On update_en, at the posedge:
    - Read c = counter[idx(update_pc)], using the pre-shift ghr.
    - Write c+1 (saturates at 2^CTR_BITS-1) if update_taken; write c-1 (saturates at 0) otherwise.
    - If HIST_BITS>0: ghr <= {ghr[HIST_BITS-2:0], update_taken}. For HIST_BITS=1: ghr <= update_taken.
  - Write latency: a prediction reflects the update from the next cycle onward (macro off).
  - Same-cycle update and prediction to different indices are independent.
- Arithmetic: counters are unsigned CTR_BITS wide. No wrap is permitted; saturation is mandatory at both ends.
- Upper PC bits [31:IDX+2] and bits [1:0] are ignored.
- No state besides the table, ghr, state and init_ptr.

Optional Feature:
- Macro: BRANCH_GSHARE_BYPASS_EN.
- Defined: in RUN, if update_en=1 and idx(update_pc) == idx(pred_pc) in the same cycle, prediction = MSB of the newly computed counter value (same-cycle forward).
- Undefined: prediction = MSB of the stored value (old value); the new value is visible the next cycle.

Test Plan:
- Init sweep, PHT_SIZE=16, CTR_BITS=2, HIST_BITS=0:
  - Deassert reset -> pred_ready=0, prediction=0 for exactly 16 cycles, then pred_ready=1.
  - Every PC predicts 0 (counter=1).
  - update_en pulsed during INIT -> no effect afterwards.
- Saturation, same config:
  - 3x update pc=0x40 taken -> prediction(0x40)=1 after the first update; counter saturates at 3.
  - Then 1x not-taken -> prediction stays 1 (counter 2).
  - 3 more not-taken -> counter 0, prediction 0.
  - A further not-taken does not wrap: one taken gives counter 1, prediction 0.
- Gshare indexing, PHT_SIZE=16, HIST_BITS=4:
  - Update pc=0x0 taken -> ghr=0001; entry 0 updated (counter 2).
  - Next, prediction(pc=0x4) uses idx 1^1=0 -> predicts 1; prediction(pc=0x0) uses idx 1 -> predicts 0.
- Reset mid-operation:
  - Train pc=0x40 to counter 3, assert reset for 1 cycle mid-RUN -> ghr=0, pred_ready=0.
  - After 16 cycles, prediction(0x40)=0.
- Same-cycle collision, HIST_BITS=0, entry of pc=0x8 at counter 1:
  - update pc=0x8 taken while pred_pc=0x8 -> prediction=1 that cycle with BRANCH_GSHARE_BYPASS_EN, 0 without.
  - Both builds predict 1 the following cycle.
- Aliasing, PHT_SIZE=16, HIST_BITS=0:
  - pc=0x0 and pc=0x40 share entry 0 -> training 0x40 taken twice makes prediction(0x0)=1.
